// File: rtl/down_timer_pkg.sv
// rtl/down_timer_pkg.sv - shared types and default sizes for the down timer
package down_timer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_PRE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/down_timer_if.sv
// rtl/down_timer_if.sv - load handshake bundle for the down timer
interface down_timer_if
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic [PRE_W-1:0] load_prescale;
  logic             load_auto;

  modport master (
    output load_valid, load_value, load_prescale, load_auto,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_value, load_prescale, load_auto,
    output load_ready
  );

endinterface

// File: rtl/down_timer_prescaler.sv
// rtl/down_timer_prescaler.sv - enable-gated divider producing a tick every div+1 enabled cycles
module down_timer_prescaler
  import down_timer_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  assign tick = en && (cnt == div);

  // While en is low the phase is held so a paused timer resumes mid-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down-counting timer with one-shot / auto-reload terminal pulse
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset_n,
  down_timer_if.slave      ld,
  input  logic             enable,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload;
  logic [PRE_W-1:0] pre_div;
  logic             auto_rl;
  logic             tc_nxt;
  logic             load_fire;
  logic             run_en;
  logic             tick;

  assign ld.load_ready = (state != RUN) && !stop;
  assign load_fire     = ld.load_valid && ld.load_ready;
  assign run_en        = (state == RUN) && enable;
  assign busy          = (state != IDLE);

  down_timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (load_fire || stop),
    .en      (run_en),
    .div     (pre_div),
    .tick    (tick)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (load_fire) begin
      count_nxt = ld.load_value;
      // A zero load terminates at once and never re-arms, whatever the mode bit says.
      if (ld.load_value == '0) begin
        tc_nxt    = 1'b1;
        state_nxt = IDLE;
      end else begin
        state_nxt = enable ? RUN : HOLD;
      end
    end else begin
      case (state)
        RUN: begin
          if (!enable) begin
            state_nxt = HOLD;
          end else if (tick) begin
            if (count > WIDTH'(1)) begin
              count_nxt = count - 1'b1;
            end else begin
              tc_nxt = 1'b1;
              if (auto_rl) begin
                count_nxt = reload;
              end else begin
                count_nxt = '0;
                state_nxt = IDLE;
              end
            end
          end
        end
        HOLD: begin
          if (enable) state_nxt = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      tc_pulse <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      tc_pulse <= tc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload  <= '0;
      pre_div <= '0;
      auto_rl <= 1'b0;
    end else if (load_fire) begin
      reload  <= ld.load_value;
      pre_div <= ld.load_prescale;
      auto_rl <= ld.load_auto;
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - directed self-checking bench for down_timer
module tb_down_timer;
  import down_timer_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       stop;
  logic [7:0] count;
  logic       tc_pulse;
  logic       busy;

  int n_checks;
  int n_fail;
  int n_pulses;

  down_timer_if #(.WIDTH(8), .PRE_W(8)) ld ();

  down_timer #(.WIDTH(8), .PRE_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld       (ld),
    .enable   (enable),
    .stop     (stop),
    .count    (count),
    .tc_pulse (tc_pulse),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] val, input logic [7:0] pre, input logic aut);
    ld.load_valid    = 1'b1;
    ld.load_value    = val;
    ld.load_prescale = pre;
    ld.load_auto     = aut;
    step();
    ld.load_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    stop     = 1'b0;
    ld.load_valid    = 1'b0;
    ld.load_value    = '0;
    ld.load_prescale = '0;
    ld.load_auto     = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_tc", tc_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ld.load_ready, 1);
    step();
    reset_n = 1'b1;
    enable  = 1'b1;

    // one-shot, prescale 0: 5,4,3,2,1,0
    do_load(8'd5, 8'd0, 1'b0);
    check("os_load_count", count, 5);
    check("os_load_busy", busy, 1);
    check("os_load_ready", ld.load_ready, 0);
    for (int i = 4; i >= 0; i--) begin
      step();
      check("os_count", count, i);
      check("os_tc", tc_pulse, (i == 0) ? 1 : 0);
      check("os_busy", busy, (i == 0) ? 0 : 1);
      check("os_ready", ld.load_ready, (i == 0) ? 1 : 0);
    end
    step();
    check("os_tc_after", tc_pulse, 0);
    check("os_count_after", count, 0);

    // auto-reload 3, prescale 2: period 9 cycles, 4 periods
    do_load(8'd3, 8'd2, 1'b1);
    check("ar_load_count", count, 3);
    n_pulses = 0;
    for (int k = 1; k <= 36; k++) begin
      step();
      check("ar_count", count, 3 - ((k % 9) / 3));
      check("ar_tc", tc_pulse, ((k % 9) == 0) ? 1 : 0);
      if (tc_pulse) n_pulses++;
    end
    check("ar_pulses", n_pulses, 4);
    check("ar_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("ar_stop_count", count, 0);
    check("ar_stop_busy", busy, 0);

    // pause in HOLD, load during HOLD, resume
    do_load(8'd4, 8'd0, 1'b0);
    check("hd_load", count, 4);
    step();
    check("hd_t1", count, 3);
    step();
    check("hd_t2", count, 2);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hd_frozen", count, 2);
      check("hd_busy", busy, 1);
    end
    check("hd_ready", ld.load_ready, 1);
    do_load(8'd7, 8'd0, 1'b0);
    check("hd_loaded", count, 7);
    step();
    check("hd_still", count, 7);
    enable = 1'b1;
    step();
    check("hd_resume", count, 7);
    step();
    check("hd_dec", count, 6);

    // stop together with load at count 6
    stop = 1'b1;
    ld.load_valid = 1'b1;
    ld.load_value = 8'd9;
    #1;
    check("st_ready", ld.load_ready, 0);
    step();
    stop = 1'b0;
    ld.load_valid = 1'b0;
    check("st_count", count, 0);
    check("st_busy", busy, 0);
    check("st_tc", tc_pulse, 0);
    step();
    check("st_tc2", tc_pulse, 0);

    // zero load with auto: single pulse only
    do_load(8'd0, 8'd0, 1'b1);
    check("z_tc", tc_pulse, 1);
    check("z_count", count, 0);
    check("z_busy", busy, 0);
    n_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tc_pulse) n_pulses++;
    end
    check("z_no_more", n_pulses, 0);
    check("z_idle", busy, 0);

    // max load, async reset at count 100
    do_load(8'd255, 8'd0, 1'b0);
    check("mx_load", count, 255);
    for (int i = 0; i < 155; i++) step();
    check("mx_count", count, 100);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_rst_count", count, 0);
    check("ar_rst_busy", busy, 0);
    check("ar_rst_tc", tc_pulse, 0);
    check("ar_rst_ready", ld.load_ready, 1);
    #3;
    reset_n = 1'b1;
    step();
    check("ar_rel_tc", tc_pulse, 0);
    check("ar_rel_count", count, 0);
    check("ar_rel_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting timer, the decrementing counterpart to the team's up counter.
- Software or an upstream FSM loads a start value over a valid/ready handshake.
- The block counts down once per prescaled tick and emits a one-cycle terminal-count pulse.
- Used for timeouts and periodic event generation; optional auto-reload gives a free-running period.

Parameters:
- WIDTH, 8, width of the counter and load value.
- PRE_W, 8, width of the prescaler divide value.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load this cycle.
- load_value  input  WIDTH  start/reload count.
- load_prescale  input  PRE_W  tick divider; count decrements every load_prescale+1 enabled cycles.
- load_auto  input  1  1 = auto-reload mode, 0 = one-shot.
- enable  input  1  count gate; low freezes count and prescaler.
- stop  input  1  synchronous abort to IDLE.
- count  output  WIDTH  current count value (registered).
- tc_pulse  output  1  one-cycle terminal-count pulse (registered).
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; count=0; tc_pulse=0; prescaler=0.
  - Reload, prescale and mode registers are cleared to 0.
  - busy=0; load_ready=1.
- States: IDLE, RUN, HOLD.
- load_ready = (state != RUN) && !stop (combinational). A load completes when load_valid && load_ready.
- Priority per cycle: reset > stop > load > tick/decrement.
- On load:
  - count <= load_value; reload <= load_value; pre_div <= load_prescale; auto <= load_auto; prescaler <= 0.
  - Next state is RUN if enable, else HOLD.
- Load with load_value=0:
  - Accepted; count=0; tc_pulse=1 on the following cycle; state -> IDLE.
  - auto is ignored for a zero load, so zero loads never produce a continuous pulse train.
- RUN:
  - enable=0 -> HOLD; count and prescaler frozen.
  - enable=1, prescaler != pre_div -> prescaler++.
  - enable=1, prescaler == pre_div -> tick: prescaler <= 0 and count decrements.
- Tick with count==1:
  - tc_pulse <= 1 for exactly one cycle.
  - auto=1: count <= reload; stay in RUN.
  - auto=0: count <= 0; state -> IDLE.
  - Period in auto mode = reload*(pre_div+1) enabled cycles.
- Tick with count>1: count <= count-1; no pulse.
- HOLD:
  - enable=1 -> RUN, resuming the exact prescaler phase.
  - Loads are accepted in HOLD.
- stop=1 in any state: state -> IDLE; count <= 0; prescaler <= 0; no tc_pulse. Reload/mode registers are kept.
- tc_pulse is never asserted on the same cycle as a stop. A pending tick on a stop cycle is discarded.
- Width rules:
  - All arithmetic is unsigned, modulo 2^WIDTH; count never wraps below 0.
  - load_value = 2^WIDTH-1 is legal.
  - pre_div = 0 means a tick on every enabled cycle.
- Reset mid-count:
  - Immediate return to reset values.
  - No tc_pulse on the cycle reset is deasserted.

Decomposition:
- Package down_timer_pkg holds:
  - state enum (IDLE, RUN, HOLD);
  - default WIDTH/PRE_W constants.
- One sub-module: down_timer_prescaler.
  - PRE_W counter with enable, clear, and divide input; outputs a tick strobe.
  - Clear is driven by load or stop.
- The top holds the FSM, count, reload/mode registers, and the tc_pulse flop.

Test Plan:
- Reset, then load 5, prescale 0, auto=0, enable=1 -> count 5,4,3,2,1,0 on consecutive cycles; tc_pulse high for one cycle with count=0; busy falls and load_ready rises in that same cycle.
- Load 3, prescale 2, auto=1 -> count decrements every 3 cycles; tc_pulse every 9 cycles; count returns to 3 after each pulse; 4 periods checked.
- Load 4, prescale 0; drop enable after 2 ticks for 5 cycles; load 7 during HOLD -> count frozen at 2 during HOLD; load accepted; count restarts at 7 when enable returns.
- During RUN at count 6: assert stop together with load_valid -> load_ready=0; count=0, IDLE next cycle; no tc_pulse.
- Load 0, auto=1 -> exactly one tc_pulse, then IDLE; no further pulses over 20 cycles.
- WIDTH=8: load 255, prescale 0; pulse reset_n low at count 100 -> count/busy/tc_pulse all 0 asynchronously; load_ready=1.
